pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage 8-bit pipeline (F, D, E, M, W). It detects load-use hazards, squashes wrong-path instructions on jmp/b, and freezes the pipe while a memory access waits. On a memory timeout it halts the core. It drives the stall, bubble and redirect controls; Decode consumes `nop_D`, and Execute, Memory and Fetch consume the rest.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_wait_timer.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the 5-stage 8-bit pipeline controller.
//   Opcode and LD function-code encodings, plus the hazard FSM state type.
package pipe_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_SD  = 4'd2;
  localparam logic [3:0] OP_ALU = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_B   = 4'd5;

  localparam logic [3:0] LD_REG = 4'd0;
  localparam logic [3:0] LD_IMM = 4'd1;
  localparam logic [3:0] LD_MEM = 4'd2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_wait_timer.sv
// wait_timer: saturating count of consecutive memory-wait cycles.
//   clk, rst   : clock, async active-high reset
//   i_clr      : clear count to 0 (highest priority)
//   i_load     : load count with 1 (first wait cycle)
//   i_en       : increment, saturating at MAX_WAIT
//   o_expired  : count has reached MAX_WAIT, one more wait cycle is too many
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(MAX_WAIT + 1) + 1;

  logic [W-1:0] r_cnt;

  // Wait-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(1);
    end else if (i_en && (r_cnt < W'(MAX_WAIT))) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt >= W'(MAX_WAIT));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the F/D/E/M/W pipe.
//   Inputs : D-stage opcode/funct/sources, E-stage opcode/funct/dest/write/taken,
//            M-stage mem_req_m / mem_ready_m handshake.
//   Outputs: stall_F/stall_D/stall_EM holds, nop_D/nop_E/nop_W bubbles,
//            redirect to Fetch, halted/error on memory timeout, stall_cnt stats.
//   All controls are Mealy (same-cycle) on state and inputs.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       insCode_d,
  input  logic [3:0]       funCode_d,
  input  logic [3:0]       srcA_d,
  input  logic [3:0]       srcB_d,
  input  logic [3:0]       insCode_e,
  input  logic [3:0]       funCode_e,
  input  logic [3:0]       dst_e,
  input  logic             writeReg_e,
  input  logic             taken_e,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_EM,
  output logic             nop_D,
  output logic             nop_E,
  output logic             nop_W,
  output logic             redirect,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t r_state;
  state_t w_next;
  logic   r_error;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_uses_a, w_uses_b, w_lu, w_br, w_mw;
  logic w_t_clr, w_t_load, w_t_en, w_expired, w_set_err;

  // ld/0 reads srcA as its source; ld/2 reads srcB as its address base.
  assign w_uses_a = ((insCode_d == OP_LD) && (funCode_d == LD_REG)) ||
                    (insCode_d == OP_SD) || (insCode_d == OP_ALU) || (insCode_d == OP_B);
  assign w_uses_b = (insCode_d == OP_ALU) || (insCode_d == OP_SD) ||
                    ((insCode_d == OP_LD) && (funCode_d == LD_MEM));
  assign w_lu = (insCode_e == OP_LD) && (funCode_e == LD_MEM) && writeReg_e &&
                (dst_e != 4'd0) &&
                ((w_uses_a && (dst_e == srcA_d)) || (w_uses_b && (dst_e == srcB_d)));
  assign w_br = (insCode_e == OP_JMP) || ((insCode_e == OP_B) && taken_e);
  assign w_mw = mem_req_m && !mem_ready_m;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_t_clr),
    .i_load    (w_t_load),
    .i_en      (w_t_en),
    .o_expired (w_expired)
  );

  // State, sticky error and stall statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_error     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_error <= r_error | w_set_err;
      if (stall_F && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  // Next-state and Mealy control outputs
  always_comb begin
    w_next    = r_state;
    w_t_clr   = 1'b0;
    w_t_load  = 1'b0;
    w_t_en    = 1'b0;
    w_set_err = 1'b0;
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    stall_EM  = 1'b0;
    nop_D     = 1'b0;
    nop_E     = 1'b0;
    nop_W     = 1'b0;
    redirect  = 1'b0;
    case (r_state)
      ST_RUN, ST_WAIT: begin
        if (w_mw) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_EM = 1'b1;
          nop_W    = 1'b1;
          if (r_state == ST_RUN) begin
            w_next   = ST_WAIT;
            w_t_load = 1'b1;
          end else if (w_expired) begin
            w_next    = ST_HALT;
            w_set_err = 1'b1;
          end else begin
            w_t_en = 1'b1;
          end
        end else begin
          // Held D/E contents re-present any hazard once the wait ends.
          w_next  = ST_RUN;
          w_t_clr = 1'b1;
          if (w_br) begin
            redirect = 1'b1;
            nop_D    = 1'b1;
            nop_E    = 1'b1;
          end else if (w_lu) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            nop_E   = 1'b1;
          end else begin
            redirect = 1'b0;
          end
        end
      end
      ST_HALT: begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_EM = 1'b1;
        nop_W    = 1'b1;
      end
      default: begin
        w_next  = ST_RUN;
        w_t_clr = 1'b1;
      end
    endcase
    if (rst) begin
      stall_F  = 1'b0;
      stall_D  = 1'b0;
      stall_EM = 1'b0;
      nop_D    = 1'b1;
      nop_E    = 1'b1;
      nop_W    = 1'b1;
      redirect = 1'b0;
    end else begin
      w_set_err = w_set_err;
    end
  end

  assign halted    = (r_state == ST_HALT);
  assign error     = r_error;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk, rst;
  logic [3:0] insCode_d, funCode_d, srcA_d, srcB_d, insCode_e, funCode_e, dst_e;
  logic writeReg_e, taken_e, mem_req_m, mem_ready_m;

  logic stall_F, stall_D, stall_EM, nop_D, nop_E, nop_W, redirect, halted, error;
  logic [15:0] stall_cnt;
  logic s4_F, s4_D, s4_EM, n4_D, n4_E, n4_W, r4, h4, e4;
  logic [3:0] stall_cnt4;

  int n_cmp = 0;
  int n_fail = 0;

  // control vector order: stall_F stall_D stall_EM nop_D nop_E nop_W redirect
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_BR     = 7'b0001101;
  localparam logic [6:0] C_FREEZE = 7'b1110010;
  localparam logic [6:0] C_RESET  = 7'b0001110;

  wire [6:0] ctl = {stall_F, stall_D, stall_EM, nop_D, nop_E, nop_W, redirect};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .insCode_d(insCode_d), .funCode_d(funCode_d),
    .srcA_d(srcA_d), .srcB_d(srcB_d), .insCode_e(insCode_e), .funCode_e(funCode_e),
    .dst_e(dst_e), .writeReg_e(writeReg_e), .taken_e(taken_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_F(stall_F), .stall_D(stall_D), .stall_EM(stall_EM), .nop_D(nop_D),
    .nop_E(nop_E), .nop_W(nop_W), .redirect(redirect), .halted(halted),
    .error(error), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .insCode_d(insCode_d), .funCode_d(funCode_d),
    .srcA_d(srcA_d), .srcB_d(srcB_d), .insCode_e(insCode_e), .funCode_e(funCode_e),
    .dst_e(dst_e), .writeReg_e(writeReg_e), .taken_e(taken_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_F(s4_F), .stall_D(s4_D), .stall_EM(s4_EM), .nop_D(n4_D),
    .nop_E(n4_E), .nop_W(n4_W), .redirect(r4), .halted(h4),
    .error(e4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] ins_d, fun_d, src_a, src_b, ins_e, fun_e, dst;
    logic       wr, taken, req, rdy;
    logic [6:0] exp_ctl;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ins_d, fun_d, src_a, src_b, ins_e, fun_e, dst,
                       input logic wr, taken, req, rdy);
    insCode_d = ins_d; funCode_d = fun_d; srcA_d = src_a; srcB_d = src_b;
    insCode_e = ins_e; funCode_e = fun_e; dst_e = dst;
    writeReg_e = wr; taken_e = taken; mem_req_m = req; mem_ready_m = rdy;
  endtask

  task automatic idle();
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // E = ld/2 to r3, D = alu reading r3 on srcB
  task automatic drive_lu();
    drive(4'd3, 4'd0, 4'd1, 4'd3, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_RESET));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    //        name         insD  funD  srcA  srcB  insE  funE  dst   wr    tk    req   rdy   exp
    vecs[0]  = '{"idle",     4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[1]  = '{"lu_alu_b", 4'd3, 4'd0, 4'd1, 4'd3, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[2]  = '{"lu_ld0_a", 4'd1, 4'd0, 4'd3, 4'd7, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[3]  = '{"r0_nohz",  4'd3, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[4]  = '{"ldimm_e",  4'd3, 4'd0, 4'd1, 4'd3, 4'd1, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[5]  = '{"no_wr",    4'd3, 4'd0, 4'd1, 4'd3, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[6]  = '{"ld2_srcA", 4'd1, 4'd2, 4'd3, 4'd5, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[7]  = '{"ld2_srcB", 4'd1, 4'd2, 4'd3, 4'd5, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[8]  = '{"jmp_d",    4'd4, 4'd0, 4'd3, 4'd3, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[9]  = '{"jmp_e",    4'd3, 4'd0, 4'd1, 4'd2, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BR};
    vecs[10] = '{"b_nt",     4'd3, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[11] = '{"b_t",      4'd3, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR};
    vecs[12] = '{"req_rdy",  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE};
    vecs[13] = '{"lu_sd_b",  4'd2, 4'd0, 4'd1, 4'd3, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[14] = '{"lu_b_a",   4'd5, 4'd0, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[15] = '{"taken_ld", 4'd3, 4'd0, 4'd1, 4'd3, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, C_LU};

    tick();
    do_reset();

    // Load-use: one stall cycle then clear, one counted stall
    drive_lu();
    #1;
    chk("lu_seq_c1", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    #1;
    chk("lu_seq_c2", 32'(ctl), 32'(C_NONE));
    chk("lu_seq_cnt", 32'(stall_cnt), 32'd1);

    // Combinational vector table, all from RUN
    for (int i = 0; i < 16; i++) begin
      tick();
      drive(vecs[i].ins_d, vecs[i].fun_d, vecs[i].src_a, vecs[i].src_b, vecs[i].ins_e,
            vecs[i].fun_e, vecs[i].dst, vecs[i].wr, vecs[i].taken, vecs[i].req, vecs[i].rdy);
      #1;
      chk(vecs[i].name, 32'(ctl), 32'(vecs[i].exp_ctl));
    end
    tick();
    idle();

    // Jump plus a 3-cycle memory wait: freeze first, redirect after
    do_reset();
    drive(4'd3, 4'd0, 4'd1, 4'd3, 4'd4, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("simul_freeze", 32'(ctl), 32'(C_FREEZE));
      tick();
    end
    mem_ready_m = 1'b1;
    #1;
    chk("simul_redirect", 32'(ctl), 32'(C_BR));
    chk("simul_cnt", 32'(stall_cnt), 32'd3);
    tick();
    idle();

    // MAX_WAIT wait cycles are legal
    do_reset();
    mem_req_m = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    mem_req_m = 1'b0;
    #1;
    chk("wait15_ctl", 32'(ctl), 32'(C_NONE));
    chk("wait15_halted", 32'(halted), 32'd0);
    tick();
    chk("wait15_halted2", 32'(halted), 32'd0);
    chk("wait15_error", 32'(error), 32'd0);

    // MAX_WAIT+1 wait cycles halt the core
    do_reset();
    mem_req_m = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_freeze", 32'(ctl), 32'(C_FREEZE));
      chk("to_not_halted", 32'(halted), 32'd0);
      tick();
    end
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_error", 32'(error), 32'd1);
    mem_req_m = 1'b0;
    drive_lu();
    #1;
    chk("halt_freeze", 32'(ctl), 32'(C_FREEZE));
    tick();
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_err_stays", 32'(error), 32'd1);
    do_reset();
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk("post_rst_error", 32'(error), 32'd0);
    chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst_ctl", 32'(ctl), 32'(C_NONE));

    // Reset in the middle of a wait returns to RUN with a cleared timer
    mem_req_m = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midwait_rst_ctl", 32'(ctl), 32'(C_RESET));
    chk("midwait_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    mem_req_m = 1'b0;
    #1;
    chk("midwait_run", 32'(ctl), 32'(C_NONE));
    mem_req_m = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    mem_req_m = 1'b0;
    tick();
    chk("midwait_no_halt", 32'(halted), 32'd0);

    // Counter saturation on the 4-bit instance
    do_reset();
    drive_lu();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt4", 32'(stall_cnt4), 32'd15);
    chk("cnt16_20", 32'(stall_cnt), 32'd20);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
